// File: rtl/arb_grant_server_if.sv
// Handshake/bus bundle between the arbiter side, the grant server and the downstream bus.
interface arb_grant_server_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int LENW = 4,
    parameter int OW   = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      gnt;
    logic [NREQ*DW-1:0]   data_in;
    logic [NREQ*LENW-1:0] len_in;
    logic                 bus_ready;
    logic                 bus_valid;
    logic [DW-1:0]        bus_data;
    logic [OW-1:0]        bus_owner;
    logic                 busy;
    logic [NREQ-1:0]      done;
    logic                 err;

    modport master (
        output req, gnt, data_in, len_in, bus_ready,
        input  bus_valid, bus_data, bus_owner, busy, done, err
    );
    modport slave (
        input  req, gnt, data_in, len_in, bus_ready,
        output bus_valid, bus_data, bus_owner, busy, done, err
    );
endinterface

// File: rtl/arb_grant_server.sv
// Grant server: captures the granted client's command, streams its burst, pulses done.
// Optional macro GNT_ABORT_EN: dropping req[owner] mid-burst aborts it with an err pulse.
module arb_grant_server #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int LENW = 4,
    parameter int OW   = 2
) (
    input logic               clk,
    input logic               rst,
    arb_grant_server_if.slave sif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [1:0]      state;
    logic [LENW-1:0] len;
    logic [LENW-1:0] beat;
    logic [OW-1:0]   gnt_idx;
    logic [DW-1:0]   cap_data;
    logic [LENW-1:0] cap_len;
    logic            gnt_ok;
    logic            hs;

    always_comb begin
        gnt_idx  = '0;
        cap_data = '0;
        cap_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sif.gnt[i]) begin
                gnt_idx  = OW'(i);
                cap_data = sif.data_in[i*DW +: DW];
                cap_len  = sif.len_in[i*LENW +: LENW];
            end
        end
        gnt_ok = $onehot(sif.gnt) && sif.req[gnt_idx];
        hs     = sif.bus_valid && sif.bus_ready;
    end

    // bus_data tracks base+beat by incrementing on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            beat          <= '0;
            sif.bus_valid <= 1'b0;
            sif.bus_data  <= '0;
            sif.bus_owner <= '0;
            sif.busy      <= 1'b0;
            sif.done      <= '0;
            sif.err       <= 1'b0;
        end else begin
            sif.done <= '0;
            sif.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sif.gnt != '0) begin
                        if (gnt_ok) begin
                            sif.bus_owner <= gnt_idx;
                            sif.bus_data  <= cap_data;
                            len           <= cap_len;
                            beat          <= '0;
                            sif.busy      <= 1'b1;
                            if (cap_len != '0) begin
                                state         <= XFER;
                                sif.bus_valid <= 1'b1;
                            end else begin
                                state    <= DONE;
                                sif.done <= ONE << gnt_idx;
                            end
                        end else begin
                            sif.err <= 1'b1;
                        end
                    end
                end
                XFER: begin
`ifdef GNT_ABORT_EN
                    if (!sif.req[sif.bus_owner]) begin
                        state         <= IDLE;
                        sif.bus_valid <= 1'b0;
                        sif.busy      <= 1'b0;
                        sif.err       <= 1'b1;
                        if (hs) begin
                            beat         <= beat + 1'b1;
                            sif.bus_data <= sif.bus_data + 1'b1;
                        end
                    end else
`endif
                    if (hs) begin
                        beat <= beat + 1'b1;
                        if (beat + 1'b1 == len) begin
                            state         <= DONE;
                            sif.bus_valid <= 1'b0;
                            sif.done      <= ONE << sif.bus_owner;
                        end else begin
                            sif.bus_data <= sif.bus_data + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    sif.busy <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    sif.busy      <= 1'b0;
                    sif.bus_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arb_grant_server.sv
// Self-checking bench for arb_grant_server: directed scenarios plus randomized bursts vs a queue model.
module tb_arb_grant_server;
    localparam int NREQ = 4, DW = 8, LENW = 4, OW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    arb_grant_server_if #(.NREQ(NREQ), .DW(DW), .LENW(LENW), .OW(OW)) sif ();

    arb_grant_server #(.NREQ(NREQ), .DW(DW), .LENW(LENW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({sif.bus_valid, sif.bus_data, sif.bus_owner, sif.busy, sif.done, sif.err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h o=%0d busy=%b done=%b err=%b, want all 0",
                     sif.bus_valid, sif.bus_data, sif.bus_owner, sif.busy, sif.done, sif.err);
        end
    endtask

    task automatic test_basic();
        sif.req = 4'b0100; sif.gnt = 4'b0100; sif.bus_ready = 1'b1;
        sif.data_in[2*DW +: DW] = 8'hFE; sif.len_in[2*LENW +: LENW] = 4'd3;
        tick();
        sif.gnt = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sif.bus_valid !== 1'b1 || sif.bus_data !== 8'(8'hFE + i) || sif.bus_owner !== 2'd2 || sif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got v=%b d=%h o=%0d busy=%b, want v=1 d=%h o=2 busy=1",
                         i, sif.bus_valid, sif.bus_data, sif.bus_owner, sif.busy, 8'(8'hFE + i));
            end
            tick();
        end
        n_checks++;
        if (sif.done !== 4'b0100 || sif.bus_valid !== 1'b0 || sif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b v=%b busy=%b, want done=0100 v=0 busy=1", sif.done, sif.bus_valid, sif.busy);
        end
        tick();
        n_checks++;
        if (sif.done !== 4'b0000 || sif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got done=%b busy=%b, want done=0000 busy=0", sif.done, sif.busy);
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int dones = 0;
        sif.req = 4'b1000; sif.gnt = 4'b1000; sif.bus_ready = 1'b0;
        sif.data_in[3*DW +: DW] = 8'h10; sif.len_in[3*LENW +: LENW] = 4'd2;
        tick();
        sif.gnt = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (sif.bus_valid !== 1'b1 || sif.bus_data !== 8'h10) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%h, want v=1 d=10", i, sif.bus_valid, sif.bus_data);
            end
        end
        sif.bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (sif.bus_valid && sif.bus_ready) accepted++;
            tick();
            if (sif.done != '0) dones++;
        end
        n_checks++;
        if (accepted != 2 || dones != 1) begin
            n_fail++;
            $display("FAIL bp_count: got beats=%0d dones=%0d, want beats=2 dones=1", accepted, dones);
        end
    endtask

    task automatic test_bad_grants();
        logic [NREQ-1:0] bad_gnt [2] = '{4'b0011, 4'b0001};
        logic [NREQ-1:0] bad_req [2] = '{4'b0011, 4'b0000};
        for (int i = 0; i < 2; i++) begin
            sif.req = bad_req[i]; sif.gnt = bad_gnt[i];
            tick();
            sif.gnt = '0;
            n_checks++;
            if (sif.err !== 1'b1 || sif.busy !== 1'b0 || sif.bus_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_gnt%0d: got err=%b busy=%b v=%b, want err=1 busy=0 v=0", i, sif.err, sif.busy, sif.bus_valid);
            end
            tick();
            n_checks++;
            if (sif.err !== 1'b0 || sif.bus_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_gnt%0d_after: got err=%b v=%b, want err=0 v=0", i, sif.err, sif.bus_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        sif.req = 4'b0011; sif.gnt = 4'b0001; sif.bus_ready = 1'b1;
        sif.len_in[0 +: LENW] = 4'd0;
        sif.data_in[DW +: DW] = 8'h77; sif.len_in[LENW +: LENW] = 4'd1;
        tick();
        sif.gnt = 4'b0010;
        n_checks++;
        if (sif.done !== 4'b0001 || sif.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zlen_done: got done=%b v=%b, want done=0001 v=0", sif.done, sif.bus_valid);
        end
        tick();
        n_checks++;
        if (sif.busy !== 1'b0 || sif.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got busy=%b v=%b, want busy=0 v=0", sif.busy, sif.bus_valid);
        end
        tick();
        sif.gnt = '0;
        n_checks++;
        if (sif.bus_valid !== 1'b1 || sif.bus_owner !== 2'd1 || sif.bus_data !== 8'h77) begin
            n_fail++;
            $display("FAIL b2b_start: got v=%b o=%0d d=%h, want v=1 o=1 d=77", sif.bus_valid, sif.bus_owner, sif.bus_data);
        end
        repeat (3) tick();
    endtask

    task automatic test_abort();
        int dones = 0;
        sif.req = 4'b0001; sif.gnt = 4'b0001; sif.bus_ready = 1'b1;
        sif.data_in[0 +: DW] = 8'h40; sif.len_in[0 +: LENW] = 4'd5;
        tick();
        sif.gnt = '0;
        tick();
        n_checks++;
        if (sif.bus_valid !== 1'b1 || sif.bus_data !== 8'h41) begin
            n_fail++;
            $display("FAIL abort_beat1: got v=%b d=%h, want v=1 d=41", sif.bus_valid, sif.bus_data);
        end
        sif.req = 4'b0000;
        tick();
`ifdef GNT_ABORT_EN
        n_checks++;
        if (sif.bus_valid !== 1'b0 || sif.err !== 1'b1 || sif.busy !== 1'b0 || sif.done !== '0) begin
            n_fail++;
            $display("FAIL abort_stop: got v=%b err=%b busy=%b done=%b, want v=0 err=1 busy=0 done=0",
                     sif.bus_valid, sif.err, sif.busy, sif.done);
        end
        repeat (8) begin
            tick();
            if (sif.done != '0 || sif.bus_valid) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d cycles of done/valid, want 0", dones);
        end
`else
        for (int i = 2; i < 5; i++) begin
            n_checks++;
            if (sif.bus_valid !== 1'b1 || sif.bus_data !== 8'(8'h40 + i) || sif.err !== 1'b0) begin
                n_fail++;
                $display("FAIL noabort_beat%0d: got v=%b d=%h err=%b, want v=1 d=%h err=0",
                         i, sif.bus_valid, sif.bus_data, sif.err, 8'(8'h40 + i));
            end
            tick();
        end
        n_checks++;
        if (sif.done !== 4'b0001) begin
            n_fail++;
            $display("FAIL noabort_done: got done=%b, want 0001", sif.done);
        end
        repeat (2) tick();
`endif
    endtask

    task automatic test_reset_mid_xfer();
        sif.req = 4'b0010; sif.gnt = 4'b0010; sif.bus_ready = 1'b0;
        sif.data_in[DW +: DW] = 8'h5A; sif.len_in[LENW +: LENW] = 4'd5;
        tick();
        sif.gnt = '0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({sif.bus_valid, sif.bus_data, sif.bus_owner, sif.busy, sif.done, sif.err} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_xfer: got v=%b d=%h o=%0d busy=%b, want all 0",
                     sif.bus_valid, sif.bus_data, sif.bus_owner, sif.busy);
        end
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if (sif.busy !== 1'b0 || sif.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: got busy=%b v=%b, want busy=0 v=0", sif.busy, sif.bus_valid);
        end
    endtask

    // Reference: a granted burst of len beats from base must deliver exactly
    // (base+i) mod 256 for i<len, in order, then exactly one done on the owner.
    task automatic test_random_bursts();
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, NREQ-1);
            logic [DW-1:0] base = DW'($urandom);
            int len = $urandom_range(0, 15);
            logic [DW-1:0] exp_q[$];
            logic [DW-1:0] got_q[$];
            logic [NREQ-1:0] done_val = '0;
            logic [DW-1:0] prev_data = '0;
            bit pending = 0;
            bit finished = 0;
            int bad = 0;
            int cyc = 0;
            sif.data_in = {$urandom, $urandom};
            sif.len_in = 16'($urandom);
            sif.data_in[k*DW +: DW] = base;
            sif.len_in[k*LENW +: LENW] = LENW'(len);
            sif.req = NREQ'($urandom) | NREQ'(1 << k);
            sif.gnt = NREQ'(1 << k);
            sif.bus_ready = 1'($urandom);
            for (int i = 0; i < len; i++) exp_q.push_back(DW'(base + i));
            tick();
            sif.gnt = '0;
            while (!finished && cyc < 300) begin
                if (pending && (sif.bus_valid !== 1'b1 || sif.bus_data !== prev_data)) bad++;
                if (sif.bus_valid && (sif.bus_owner !== OW'(k) || sif.busy !== 1'b1)) bad++;
                if (sif.done != '0) begin
                    done_val = sif.done;
                    finished = 1;
                end else begin
                    sif.bus_ready = ($urandom_range(0, 3) != 0);
                    pending = sif.bus_valid && !sif.bus_ready;
                    prev_data = sif.bus_data;
                    if (sif.bus_valid && sif.bus_ready) got_q.push_back(sif.bus_data);
                    tick();
                    cyc++;
                end
            end
            n_checks++;
            if (!finished || done_val !== NREQ'(1 << k) || got_q.size() != len || bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d: done=%b beats=%0d protocol_errs=%0d timeout=%0b, want done=%b beats=%0d errs=0",
                         n, done_val, got_q.size(), bad, !finished, NREQ'(1 << k), len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    n_checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_beat%0d: got %h, want %h", n, i, got_q[i], exp_q[i]);
                    end
                end
            end
            tick();
            n_checks++;
            if (sif.busy !== 1'b0 || sif.done !== '0) begin
                n_fail++;
                $display("FAIL rand%0d_exit: got busy=%b done=%b, want busy=0 done=0", n, sif.busy, sif.done);
            end
        end
    endtask

    initial begin
        sif.req = '0; sif.gnt = '0; sif.data_in = '0; sif.len_in = '0; sif.bus_ready = 1'b0;
        #1;
        test_reset();
        #12 rst = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_grants();
        test_back_to_back();
        test_abort();
        test_reset_mid_xfer();
        test_random_bursts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
